// File: rtl/reservation_station_pkg.sv
// Shared CPU definitions: ALU opcodes, ROB tag width, RS depth and the
// entry/operand/CDB record types used by the reservation station.
package reservation_station_pkg;

  localparam int XLEN     = 32;
  localparam int OP_W     = 5;
  localparam int ROB_W    = 4;
  localparam int RS_DEPTH = 8;

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [ROB_W-1:0] rob_id_t;
  typedef logic [OP_W-1:0]  op_t;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9
  } alu_op_e;

  // One source operand: busy/q/val correspond to qj_busy/qj/vj (or the k side).
  typedef struct packed {
    logic    busy;
    rob_id_t q;
    word_t   val;
  } operand_t;

  typedef struct packed {
    logic    valid;
    rob_id_t robId;
    word_t   value;
  } cdb_t;

  typedef struct packed {
    logic     busy;
    op_t      op;
    operand_t j;
    operand_t k;
    word_t    imm;
    word_t    pc;
    rob_id_t  robId;
  } rs_entry_t;

  // Resolve a pending operand against both result buses.
  function automatic operand_t wakeOperand(operand_t opnd, cdb_t aluCdb, cdb_t lsbCdb);
    operand_t res;
    res = opnd;
    if (opnd.busy) begin
      if (aluCdb.valid && aluCdb.robId == opnd.q) begin
        res.val  = aluCdb.value;
        res.busy = 1'b0;
      end else if (lsbCdb.valid && lsbCdb.robId == opnd.q) begin
        res.val  = lsbCdb.value;
        res.busy = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Issue, operand, CDB, control and ALU-dispatch signals of the reservation station.
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic    rdy;
  logic    rollback;
  logic    issue_valid;
  op_t     issue_op;
  rob_id_t issue_rob_id;
  word_t   issue_pc;
  word_t   issue_imm;
  word_t   rs1_val;
  logic    rs1_busy;
  rob_id_t rs1_q;
  word_t   rs2_val;
  logic    rs2_busy;
  rob_id_t rs2_q;
  logic    alu_cdb_valid;
  rob_id_t alu_cdb_rob_id;
  word_t   alu_cdb_value;
  logic    lsb_cdb_valid;
  rob_id_t lsb_cdb_rob_id;
  word_t   lsb_cdb_value;
  logic    rs_full;
  logic    alu_valid;
  op_t     alu_op;
  word_t   alu_a;
  word_t   alu_b;
  word_t   alu_imm;
  word_t   alu_pc;
  rob_id_t alu_rob_id;

  modport slave (
    input  rdy, rollback, issue_valid, issue_op, issue_rob_id, issue_pc, issue_imm,
    input  rs1_val, rs1_busy, rs1_q, rs2_val, rs2_busy, rs2_q,
    input  alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
    input  lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value,
    output rs_full, alu_valid, alu_op, alu_a, alu_b, alu_imm, alu_pc, alu_rob_id
  );

  modport master (
    output rdy, rollback, issue_valid, issue_op, issue_rob_id, issue_pc, issue_imm,
    output rs1_val, rs1_busy, rs1_q, rs2_val, rs2_busy, rs2_q,
    output alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
    output lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value,
    input  rs_full, alu_valid, alu_op, alu_a, alu_b, alu_imm, alu_pc, alu_rob_id
  );

endinterface

// File: rtl/reservation_station_prio_enc.sv
// Lowest-index one-hot priority encoder with a found flag.
module rs_prio_enc
  import reservation_station_pkg::*;
#(
  parameter int W = RS_DEPTH
) (
  input  logic [W-1:0] req_i,
  output logic [W-1:0] grant_o,
  output logic         found_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant_o = req_i & (~req_i + W'(1));
  assign found_o = |req_i;

endmodule

// File: rtl/reservation_station.sv
// 8-entry ALU reservation station: issue with CDB bypass, per-cycle wakeup,
// lowest-index dispatch into registered ALU outputs, and rollback flush.
module reservation_station
  import reservation_station_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  reservation_station_if.slave  rsBus
);

  rs_entry_t            ent_q [RS_DEPTH];
  rs_entry_t            ent_d [RS_DEPTH];
  logic [RS_DEPTH-1:0]  busyVec, readyVec, freeGrant, readyGrant;
  logic                 freeFound, readyFound;
  cdb_t                 aluCdb, lsbCdb;
  operand_t             rs1In, rs2In, rs1New, rs2New;

  logic    aluValid_q, aluValid_d;
  op_t     aluOp_q, aluOp_d;
  word_t   aluA_q, aluA_d, aluB_q, aluB_d, aluImm_q, aluImm_d, aluPc_q, aluPc_d;
  rob_id_t aluRob_q, aluRob_d;

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      busyVec[i]  = ent_q[i].busy;
      readyVec[i] = ent_q[i].busy & ~ent_q[i].j.busy & ~ent_q[i].k.busy;
    end
  end

  rs_prio_enc #(.W(RS_DEPTH)) uFreeSel  (.req_i(~busyVec), .grant_o(freeGrant),  .found_o(freeFound));
  rs_prio_enc #(.W(RS_DEPTH)) uReadySel (.req_i(readyVec), .grant_o(readyGrant), .found_o(readyFound));

  assign rsBus.rs_full = &busyVec;

  assign aluCdb = '{valid: rsBus.alu_cdb_valid, robId: rsBus.alu_cdb_rob_id, value: rsBus.alu_cdb_value};
  assign lsbCdb = '{valid: rsBus.lsb_cdb_valid, robId: rsBus.lsb_cdb_rob_id, value: rsBus.lsb_cdb_value};
  assign rs1In  = '{busy: rsBus.rs1_busy, q: rsBus.rs1_q, val: rsBus.rs1_val};
  assign rs2In  = '{busy: rsBus.rs2_busy, q: rsBus.rs2_q, val: rsBus.rs2_val};
  assign rs1New = wakeOperand(rs1In, aluCdb, lsbCdb);
  assign rs2New = wakeOperand(rs2In, aluCdb, lsbCdb);

  // Readiness comes from registered state, so a wakeup and the dispatch of
  // the same entry never coincide; issue only targets free slots.
  always_comb begin
    ent_d      = ent_q;
    aluValid_d = aluValid_q;
    aluOp_d    = aluOp_q;
    aluA_d     = aluA_q;
    aluB_d     = aluB_q;
    aluImm_d   = aluImm_q;
    aluPc_d    = aluPc_q;
    aluRob_d   = aluRob_q;
    if (rsBus.rdy) begin
      aluValid_d = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (ent_q[i].busy) begin
          ent_d[i].j = wakeOperand(ent_q[i].j, aluCdb, lsbCdb);
          ent_d[i].k = wakeOperand(ent_q[i].k, aluCdb, lsbCdb);
        end
        if (readyFound && readyGrant[i]) begin
          ent_d[i].busy = 1'b0;
          aluValid_d    = 1'b1;
          aluOp_d       = ent_q[i].op;
          aluA_d        = ent_q[i].j.val;
          aluB_d        = ent_q[i].k.val;
          aluImm_d      = ent_q[i].imm;
          aluPc_d       = ent_q[i].pc;
          aluRob_d      = ent_q[i].robId;
        end
        if (rsBus.issue_valid && freeFound && freeGrant[i]) begin
          ent_d[i] = '{busy: 1'b1, op: rsBus.issue_op, j: rs1New, k: rs2New,
                       imm: rsBus.issue_imm, pc: rsBus.issue_pc, robId: rsBus.issue_rob_id};
        end
        if (rsBus.rollback) begin
          ent_d[i].busy = 1'b0;
        end
      end
      if (rsBus.rollback) begin
        aluValid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      aluValid_q <= 1'b0;
      aluOp_q    <= '0;
      aluA_q     <= '0;
      aluB_q     <= '0;
      aluImm_q   <= '0;
      aluPc_q    <= '0;
      aluRob_q   <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      aluValid_q <= aluValid_d;
      aluOp_q    <= aluOp_d;
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      aluImm_q   <= aluImm_d;
      aluPc_q    <= aluPc_d;
      aluRob_q   <= aluRob_d;
    end
  end

  assign rsBus.alu_valid  = aluValid_q;
  assign rsBus.alu_op     = aluOp_q;
  assign rsBus.alu_a      = aluA_q;
  assign rsBus.alu_b      = aluB_q;
  assign rsBus.alu_imm    = aluImm_q;
  assign rsBus.alu_pc     = aluPc_q;
  assign rsBus.alu_rob_id = aluRob_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed, table-driven bench for reservation_station: each vector is one
// cycle of inputs plus the outputs expected after that clock edge.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reservation_station_if rsBus();

  reservation_station dut (
    .clk   (clk),
    .rst   (rst),
    .rsBus (rsBus)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  op;
    logic [3:0]  rob;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] v1;
    logic        b1;
    logic [3:0]  q1;
    logic [31:0] v2;
    logic        b2;
    logic [3:0]  q2;
    logic        av;
    logic [3:0]  aid;
    logic [31:0] aval;
    logic        lv;
    logic [3:0]  lid;
    logic [31:0] lval;
    logic        stall;
    logic        rb;
    logic        eValid;
    logic        eFull;
    logic [4:0]  eOp;
    logic [31:0] eA;
    logic [31:0] eB;
    logic [31:0] eImm;
    logic [31:0] ePc;
    logic [3:0]  eRob;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl [7];
  vec_t idle;

  task automatic checkEq(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveInputs(vec_t v);
    rsBus.rdy            = ~v.stall;
    rsBus.rollback       = v.rb;
    rsBus.issue_valid    = v.iv;
    rsBus.issue_op       = v.op;
    rsBus.issue_rob_id   = v.rob;
    rsBus.issue_pc       = v.pc;
    rsBus.issue_imm      = v.imm;
    rsBus.rs1_val        = v.v1;
    rsBus.rs1_busy       = v.b1;
    rsBus.rs1_q          = v.q1;
    rsBus.rs2_val        = v.v2;
    rsBus.rs2_busy       = v.b2;
    rsBus.rs2_q          = v.q2;
    rsBus.alu_cdb_valid  = v.av;
    rsBus.alu_cdb_rob_id = v.aid;
    rsBus.alu_cdb_value  = v.aval;
    rsBus.lsb_cdb_valid  = v.lv;
    rsBus.lsb_cdb_rob_id = v.lid;
    rsBus.lsb_cdb_value  = v.lval;
  endtask

  task automatic applyStimulus(vec_t v);
    driveInputs(v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string tag, vec_t v);
    checkEq({tag, " alu_valid"}, 32'(rsBus.alu_valid), 32'(v.eValid));
    checkEq({tag, " rs_full"}, 32'(rsBus.rs_full), 32'(v.eFull));
    if (v.eValid) begin
      checkEq({tag, " alu_op"}, 32'(rsBus.alu_op), 32'(v.eOp));
      checkEq({tag, " alu_a"}, rsBus.alu_a, v.eA);
      checkEq({tag, " alu_b"}, rsBus.alu_b, v.eB);
      checkEq({tag, " alu_imm"}, rsBus.alu_imm, v.eImm);
      checkEq({tag, " alu_pc"}, rsBus.alu_pc, v.ePc);
      checkEq({tag, " alu_rob_id"}, 32'(rsBus.alu_rob_id), 32'(v.eRob));
    end
  endtask

  task automatic runVec(string tag, vec_t v);
    applyStimulus(v);
    checkOutput(tag, v);
  endtask

  task automatic checkCleared(string tag);
    checkEq({tag, " alu_valid"}, 32'(rsBus.alu_valid), 32'd0);
    checkEq({tag, " alu_op"}, 32'(rsBus.alu_op), 32'd0);
    checkEq({tag, " alu_a"}, rsBus.alu_a, 32'd0);
    checkEq({tag, " alu_b"}, rsBus.alu_b, 32'd0);
    checkEq({tag, " alu_imm"}, rsBus.alu_imm, 32'd0);
    checkEq({tag, " alu_pc"}, rsBus.alu_pc, 32'd0);
    checkEq({tag, " alu_rob_id"}, 32'(rsBus.alu_rob_id), 32'd0);
    checkEq({tag, " rs_full"}, 32'(rsBus.rs_full), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle = '{default: 0};

    // Ready ADD, pending rs1 woken by the ALU bus, rs2 bypassed from the LSB bus on issue.
    tbl[0] = '{iv: 1, op: ALU_ADD, rob: 3, pc: 32'h100, imm: 32'h11, v1: 5, v2: 7, default: 0};
    tbl[1] = '{eValid: 1, eOp: ALU_ADD, eA: 5, eB: 7, eImm: 32'h11, ePc: 32'h100, eRob: 3, default: 0};
    tbl[2] = '{iv: 1, op: ALU_SUB, rob: 5, pc: 32'h104, imm: 32'h22, v1: 32'hDEAD, b1: 1, q1: 2, v2: 3, default: 0};
    tbl[3] = '{av: 1, aid: 2, aval: 32'h10, default: 0};
    tbl[4] = '{eValid: 1, eOp: ALU_SUB, eA: 32'h10, eB: 3, eImm: 32'h22, ePc: 32'h104, eRob: 5, default: 0};
    tbl[5] = '{iv: 1, op: ALU_AND, rob: 6, pc: 32'h108, imm: 32'h33, v1: 9, v2: 32'hBEEF, b2: 1, q2: 4,
               lv: 1, lid: 4, lval: 32'h55, default: 0};
    tbl[6] = '{eValid: 1, eOp: ALU_AND, eA: 9, eB: 32'h55, eImm: 32'h33, ePc: 32'h108, eRob: 6, default: 0};

    // Reset is held with rdy low to show reset wins over the freeze.
    rst = 1'b1;
    driveInputs('{stall: 1, default: 0});
    repeat (2) @(posedge clk);
    #1;
    checkCleared("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      runVec($sformatf("tbl[%0d]", i), tbl[i]);
    end

    // Fill all eight entries with rs1 pending on tags 8..15.
    for (int i = 0; i < 8; i++) begin
      runVec($sformatf("fill8[%0d]", i),
             '{iv: 1, op: ALU_OR, rob: 4'(i), pc: 32'h2000 + 32'(4 * i), imm: 32'(i),
               v1: 32'hDEAD0000, b1: 1, q1: 4'(8 + i), v2: 32'(100 + i), eFull: (i == 7), default: 0});
    end
    runVec("issue when full", '{iv: 1, op: ALU_ADD, rob: 12, v1: 1, v2: 2, eFull: 1, default: 0});
    runVec("full idle", '{eFull: 1, default: 0});
    runVec("wake 1 and 6", '{av: 1, aid: 9, aval: 32'h111, lv: 1, lid: 14, lval: 32'h666, eFull: 1, default: 0});
    runVec("dispatch idx1", '{eValid: 1, eOp: ALU_OR, eA: 32'h111, eB: 101, eImm: 1, ePc: 32'h2004, eRob: 1, default: 0});
    runVec("rdy low hold", '{stall: 1, av: 1, aid: 8, aval: 32'h888,
                             eValid: 1, eOp: ALU_OR, eA: 32'h111, eB: 101, eImm: 1, ePc: 32'h2004, eRob: 1, default: 0});
    runVec("dispatch idx6", '{eValid: 1, eOp: ALU_OR, eA: 32'h666, eB: 106, eImm: 6, ePc: 32'h2018, eRob: 6, default: 0});
    runVec("after idx6", idle);
    runVec("flush six", '{rb: 1, iv: 1, op: ALU_ADD, rob: 13, v1: 1, v2: 2, default: 0});
    runVec("after flush six", idle);

    // Five pending entries, then rollback alongside a ready issue; later wakes must find nothing.
    for (int i = 0; i < 5; i++) begin
      runVec($sformatf("fill5[%0d]", i),
             '{iv: 1, op: ALU_XOR, rob: 4'(i), pc: 32'h3000 + 32'(4 * i), v1: 32'hDEAD0000,
               b1: 1, q1: 4'(1 + i), v2: 32'(i), default: 0});
    end
    runVec("rollback+issue", '{rb: 1, iv: 1, op: ALU_ADD, rob: 13, v1: 1, v2: 2, default: 0});
    for (int k = 0; k < 3; k++) begin
      runVec($sformatf("post-rollback wake[%0d]", k),
             '{av: 1, aid: 4'(1 + k), aval: 32'h70, lv: 1, lid: 4'(4 + (k % 2)), lval: 32'h71, default: 0});
    end
    runVec("post-rollback idle", idle);

    // Back-to-back ready issues: the second is written while the first dispatches.
    runVec("b2b issue A", '{iv: 1, op: ALU_SLT, rob: 2, pc: 32'h400, imm: 32'h44, v1: 32'hA, v2: 32'hB, default: 0});
    runVec("b2b issue B", '{iv: 1, op: ALU_SLTU, rob: 10, pc: 32'h404, imm: 32'h45, v1: 32'hC, v2: 32'hD,
                            eValid: 1, eOp: ALU_SLT, eA: 32'hA, eB: 32'hB, eImm: 32'h44, ePc: 32'h400, eRob: 2, default: 0});
    runVec("b2b dispatch B", '{eValid: 1, eOp: ALU_SLTU, eA: 32'hC, eB: 32'hD, eImm: 32'h45, ePc: 32'h404, eRob: 10, default: 0});
    runVec("b2b idle", idle);

    // Reset with a ready instruction waiting to dispatch discards it.
    runVec("inflight issue", '{iv: 1, op: ALU_SRL, rob: 9, pc: 32'h500, v1: 32'h77, v2: 1, default: 0});
    rst = 1'b1;
    driveInputs('{stall: 1, default: 0});
    @(posedge clk);
    #1;
    checkCleared("mid reset");
    rst = 1'b0;
    runVec("after mid reset", idle);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
